// File: rtl/systolic_array_sequencer_pkg.sv
// Shared constants and FSM state encoding for the systolic array sequencer.
package sa_seq_pkg;
  localparam int ROWS   = 8;
  localparam int DATA_W = 64;
  localparam int LANE_W = 8;

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, STREAM, DRAIN, DONE} state_t;
endpackage

// File: rtl/systolic_array_sequencer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head word is visible on rdata while not empty.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage carries data only, so it is left out of reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/systolic_array_sequencer.sv
// Initiator-side controller for the 8x8 systolic array: loads weights, streams inputs
// under result-FIFO credit, and returns results on a ready/valid stream.
module systolic_array_sequencer #(
  parameter int ROWS          = sa_seq_pkg::ROWS,
  parameter int DATA_W        = sa_seq_pkg::DATA_W,
  parameter int OUT_DEPTH     = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              float_mode,
  input  logic [CNT_W-1:0]  num_inputs,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] x_data,
  output logic              sa_float,
  output logic [ROWS-1:0]   sa_load,
  output logic [DATA_W-1:0] sa_input_value,
  output logic              sa_input_valid,
  input  logic              sa_output_valid,
  input  logic [DATA_W-1:0] sa_output_value,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              busy,
  output logic              done,
  output logic              spurious_err
);
  import sa_seq_pkg::*;

  localparam int OW = $clog2(OUT_DEPTH+1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES+1);
  localparam logic [OW:0] DEPTH_L = (OW+1)'(OUT_DEPTH);

  state_t            state;
  logic [RW-1:0]     row;
  logic [SW-1:0]     settle_cnt;
  logic [CNT_W-1:0]  num_r, issued, received;
  logic [OW-1:0]     outstanding;
  logic              done_r;
  logic              w_hs, x_hs, res_push, res_pop;
  logic              fifo_full, fifo_empty;
  logic [OW-1:0]     fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [OW:0]       credit_used;

  assign w_hs     = w_valid && w_ready;
  assign x_hs     = x_valid && x_ready;
  assign res_push = sa_output_valid && (outstanding != '0);
  assign res_pop  = y_valid && y_ready;

  // a slot freed by a same-cycle pop is only counted from the next cycle
  assign credit_used = (OW+1)'(outstanding) + (OW+1)'(fifo_count);
  assign w_ready     = (state == LOAD);
  assign x_ready     = (state == STREAM) && (issued < num_r) && (credit_used < DEPTH_L);

  assign y_valid = !fifo_empty;
  assign y_data  = y_valid ? fifo_head : '0;
  assign done    = done_r;
  assign busy    = (state != IDLE) || done_r;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_result_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_push),
    .wdata (sa_output_value),
    .pop   (res_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      row            <= '0;
      settle_cnt     <= '0;
      num_r          <= '0;
      issued         <= '0;
      received       <= '0;
      outstanding    <= '0;
      done_r         <= 1'b0;
      spurious_err   <= 1'b0;
      sa_float       <= 1'b0;
      sa_load        <= '0;
      sa_input_value <= '0;
      sa_input_valid <= 1'b0;
    end else begin
      sa_load        <= '0;
      sa_input_valid <= 1'b0;
      sa_input_value <= '0;
      done_r         <= (state == DONE);

      // result capture runs in every state; the array cannot be stalled
      if (sa_output_valid) begin
        if (outstanding != '0) received <= received + 1'b1;
        else                   spurious_err <= 1'b1;
      end
      case ({x_hs, res_push})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      case (state)
        IDLE: begin
          if (start && !done_r) begin
            sa_float     <= float_mode;
            num_r        <= num_inputs;
            spurious_err <= 1'b0;
            row          <= '0;
            issued       <= '0;
            received     <= '0;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (w_hs) begin
            sa_load        <= ROWS'(1) << row;
            sa_input_value <= w_data;
            row            <= row + 1'b1;
            if (row == RW'(ROWS-1)) begin
              settle_cnt <= '0;
              state      <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES-1)) state <= (num_r == '0) ? DONE : STREAM;
          else                                     settle_cnt <= settle_cnt + 1'b1;
        end
        STREAM: begin
          if (x_hs) begin
            sa_input_valid <= 1'b1;
            sa_input_value <= x_data;
            issued         <= issued + 1'b1;
          end
          if (issued == num_r) state <= DRAIN;
        end
        DRAIN: begin
          if ((received == num_r) && fifo_empty) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Scoreboard bench: a latency-10 "x+1" array model feeds the sequencer; expected results are queued at issue time.
module tb_systolic_array_sequencer;
  localparam int DW = 64, NR = 8, OUT_DEPTH = 8, SETTLE = 4, CNT_W = 16, LAT = 10;
  localparam int LW = sa_seq_pkg::LANE_W;

  logic clk, rst, start, float_mode;
  logic [CNT_W-1:0] num_inputs;
  logic w_valid, w_ready, x_valid, x_ready;
  logic [DW-1:0] w_data, x_data;
  logic sa_float, sa_input_valid, sa_output_valid;
  logic [NR-1:0] sa_load;
  logic [DW-1:0] sa_input_value, sa_output_value, y_data;
  logic y_valid, y_ready, busy, done, spurious_err;

  systolic_array_sequencer #(.ROWS(NR), .DATA_W(DW), .OUT_DEPTH(OUT_DEPTH),
    .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .float_mode(float_mode), .num_inputs(num_inputs),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .sa_float(sa_float), .sa_load(sa_load), .sa_input_value(sa_input_value),
    .sa_input_valid(sa_input_valid), .sa_output_valid(sa_output_valid),
    .sa_output_value(sa_output_value), .y_valid(y_valid), .y_ready(y_ready),
    .y_data(y_data), .busy(busy), .done(done), .spurious_err(spurious_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: each accepted input comes back as x+1 exactly LAT cycles later.
  logic [LAT-1:0] pv;
  logic [DW-1:0]  pd [LAT];
  logic           spur;
  logic [DW-1:0]  spur_val;
  always @(posedge clk or posedge rst) begin
    if (rst) pv <= '0;
    else begin
      pv    <= {pv[LAT-2:0], sa_input_valid};
      pd[0] <= sa_input_value + 64'd1;
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end
  assign sa_output_valid = pv[LAT-1] | spur;
  assign sa_output_value = spur ? spur_val : pd[LAT-1];

  int n_cmp, n_bad, pop_cnt, done_cnt, x_hs_cnt, yr_mode;
  logic [DW-1:0] exp_q [$];
  bit float_watch, float_bad;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: pops and compares on every y handshake; also counts done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (y_valid && y_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL y_data: got %0h, expected no result", y_data);
        end else check("y_data", y_data, exp_q.pop_front());
        pop_cnt++;
      end
      if (done) done_cnt++;
      if (float_watch && busy && sa_float !== 1'b1) float_bad = 1'b1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (yr_mode)
        0:       y_ready = 1'b0;
        1:       y_ready = 1'b1;
        default: y_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  function automatic logic [DW-1:0] row_val(input int r);
    return 64'h0101_0101_0101_0101 * (r + 1);
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int l = 0; l < DW / LW; l++) v[l*LW +: LW] = LW'($urandom);
    return v;
  endfunction

  task automatic pulse_start(input bit fm, input int n);
    @(posedge clk); #1;
    start = 1'b1; float_mode = fm; num_inputs = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_weights(input bit do_timing);
    int k;
    w_valid = 1'b1;
    w_data  = row_val(0);
    for (k = 0; k < 20 && !w_ready; k++) @(negedge clk);
    if (!w_ready) begin
      timeout("w_ready");
      w_valid = 1'b0;
      return;
    end
    for (int r = 0; r < NR; r++) begin
      @(posedge clk); #1;
      if (r < NR - 1) w_data = row_val(r + 1);
      else begin w_valid = 1'b0; w_data = '0; end
      @(negedge clk);
      check("sa_load", DW'(sa_load), DW'(1) << r);
      check("sa_load_value", sa_input_value, row_val(r));
    end
    if (do_timing) begin
      for (k = 2; k < SETTLE + 12; k++) begin
        @(negedge clk);
        if (k == 2) check("sa_load_idle", DW'(sa_load), '0);
        if (done) break;
      end
      check("done_latency", DW'(k), DW'(SETTLE + 2));
      @(negedge clk);
      check("busy_after_done", DW'(busy), '0);
    end
  endtask

  task automatic feed_x(input int n, input bit rnd);
    logic [DW-1:0] val;
    int waited;
    for (int i = 0; i < n; i++) begin
      val = rnd ? rand_vec() : DW'(5 + i);
      x_valid = 1'b1;
      x_data  = val;
      @(negedge clk);
      waited = 0;
      while (!x_ready && waited < 400) begin @(negedge clk); waited++; end
      if (!x_ready) begin
        timeout("x_ready");
        x_valid = 1'b0;
        return;
      end
      @(posedge clk);
      exp_q.push_back(val + 64'd1);
      x_hs_cnt++;
      #1;
      x_valid = 1'b0;
      x_data  = '0;
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done(input string name, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; return; end
    end
    timeout(name);
  endtask

  task automatic run_job(input int n, input bit fm, input bit rnd, input int yrm);
    int d0;
    bit seen;
    yr_mode  = yrm;
    pop_cnt  = 0;
    x_hs_cnt = 0;
    d0 = done_cnt;
    pulse_start(fm, n);
    check("spurious_cleared", DW'(spurious_err), '0);
    check("sa_float", DW'(sa_float), DW'(fm));
    load_weights(n == 0);
    if (n > 0) begin
      feed_x(n, rnd);
      wait_done("done", seen);
      if (seen) check("pops_at_done", DW'(pop_cnt), DW'(n));
      check("queue_empty", DW'(exp_q.size()), '0);
      check("spurious_err", DW'(spurious_err), '0);
    end
    repeat (3) @(negedge clk);
    check("done_once", DW'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    bit seen;
    int d0;
    n_cmp = 0; n_bad = 0; pop_cnt = 0; done_cnt = 0; x_hs_cnt = 0; yr_mode = 1;
    rst = 1'b1; start = 1'b0; float_mode = 1'b0; num_inputs = '0;
    w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0;
    spur = 1'b0; spur_val = '0; y_ready = 1'b0;
    float_watch = 1'b0; float_bad = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", DW'(busy), '0);
    check("rst_outs", DW'({done, y_valid, sa_input_valid, sa_float, spurious_err, w_ready, x_ready}), '0);
    check("rst_sa_load", DW'(sa_load), '0);
    @(posedge clk); #1 rst = 1'b0;

    // weight load with no inputs
    run_job(0, 1'b0, 1'b0, 1);

    // stream x = 5,6,7
    run_job(3, 1'b0, 1'b0, 1);

    // backpressure: credit must stop issue at OUT_DEPTH
    yr_mode = 0; pop_cnt = 0; x_hs_cnt = 0;
    pulse_start(1'b0, 20);
    load_weights(1'b0);
    fork feed_x(20, 1'b1); join_none
    repeat (80) @(negedge clk);
    check("bp_handshakes", DW'(x_hs_cnt), DW'(OUT_DEPTH));
    check("bp_x_ready", DW'(x_ready), '0);
    yr_mode = 1;
    wait_done("bp_done", seen);
    check("bp_pops", DW'(pop_cnt), 64'd20);
    check("bp_queue_empty", DW'(exp_q.size()), '0);
    repeat (2) @(negedge clk);

    // spurious result in IDLE
    @(posedge clk); #1 spur = 1'b1; spur_val = 64'hdead_beef;
    @(posedge clk); #1 spur = 1'b0;
    @(negedge clk);
    check("spurious_set", DW'(spurious_err), 64'd1);
    check("spurious_no_push", DW'(y_valid), '0);
    run_job(2, 1'b0, 1'b1, 1);

    // reset mid-STREAM with two results queued
    yr_mode = 0;
    pulse_start(1'b1, 10);
    load_weights(1'b0);
    feed_x(2, 1'b1);
    repeat (16) @(negedge clk);
    check("pre_rst_y_valid", DW'(y_valid), 64'd1);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("rst_mid_outs", DW'({y_valid, busy, done, sa_input_valid, sa_float}), '0);
    check("rst_mid_sa_load", DW'(sa_load), '0);
    check("rst_mid_sa_value", sa_input_value, '0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_no_done", DW'(done_cnt - d0), '0);
    run_job(6, 1'b0, 1'b1, 2);

    // float mode held; a start while busy is ignored
    yr_mode = 1; pop_cnt = 0; float_bad = 1'b0;
    d0 = done_cnt;
    pulse_start(1'b1, 4);
    float_watch = 1'b1;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 start = 1'b1; float_mode = 1'b0; num_inputs = CNT_W'(9);
        @(posedge clk); #1 start = 1'b0;
      end
    join_none
    load_weights(1'b0);
    feed_x(4, 1'b1);
    wait_done("mode_done", seen);
    check("mode_pops", DW'(pop_cnt), 64'd4);
    repeat (3) @(negedge clk);
    float_watch = 1'b0;
    check("mode_float_held", DW'(float_bad), '0);
    check("mode_float_idle", DW'(sa_float), 64'd1);
    check("mode_done_once", DW'(done_cnt - d0), 64'd1);

    // randomized jobs
    for (int j = 0; j < 4; j++) run_job($urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'b1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
